// File: rtl/multi_clk_div.sv
// Multi-channel programmable clock divider.
// Each channel divides clk_in by 2*(div+1). clk_out is a 50% duty square wave
// and tick is a one-cycle strobe in the cycle clk_out toggles.
// New divisors go into a per-channel shadow register first. They take effect at
// the next wrap, or at a sync pulse, so a half-period already in progress is
// never cut short.
module multi_clk_div #(
    parameter int CHANNELS    = 2,
    parameter int WIDTH       = 32,
    parameter int DEFAULT_DIV = 500000
) (
    input  logic                clk_in,
    input  logic                rst,
    input  logic [CHANNELS-1:0] en,
    input  logic                sync,
    input  logic                ld_valid,
    input  logic [3:0]          ld_ch,
    input  logic [WIDTH-1:0]    ld_div,
    output logic                ld_ready,
    output logic [CHANNELS-1:0] clk_out,
    output logic [CHANNELS-1:0] tick
);

    localparam logic [WIDTH-1:0] RESET_DIV = WIDTH'(DEFAULT_DIV);

    logic [WIDTH-1:0]    cnt      [CHANNELS];
    logic [WIDTH-1:0]    div      [CHANNELS];
    logic [WIDTH-1:0]    pend_div [CHANNELS];
    logic [CHANNELS-1:0] pend;

    // pend widened to the full 4-bit channel index range so that an
    // out-of-range ld_ch never indexes past the real flags
    logic [15:0] pend_wide;
    logic        ch_in_range;
    logic        accept;

    assign pend_wide   = 16'(pend);
    assign ch_in_range = ({28'd0, ld_ch} < 32'(CHANNELS));
    assign ld_ready    = ch_in_range && !pend_wide[ld_ch] && !rst;
    assign accept      = ld_valid && ld_ready;

    // Per-channel counting, wrapping, divisor swap and load capture
    always_ff @(posedge clk_in) begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (rst) begin
                cnt[i]      <= '0;
                div[i]      <= RESET_DIV;
                pend_div[i] <= '0;
                pend[i]     <= 1'b0;
                clk_out[i]  <= 1'b0;
                tick[i]     <= 1'b0;
            end else begin
                if (sync) begin
                    cnt[i]     <= '0;
                    clk_out[i] <= 1'b0;
                    tick[i]    <= 1'b0;
                    if (pend[i]) begin
                        div[i]  <= pend_div[i];
                        pend[i] <= 1'b0;
                    end
                end else if (en[i]) begin
                    if (cnt[i] == div[i]) begin
                        cnt[i]     <= '0;
                        clk_out[i] <= ~clk_out[i];
                        tick[i]    <= 1'b1;
                        if (pend[i]) begin
                            div[i]  <= pend_div[i];
                            pend[i] <= 1'b0;
                        end
                    end else begin
                        cnt[i]  <= cnt[i] + WIDTH'(1);
                        tick[i] <= 1'b0;
                    end
                end else begin
                    tick[i] <= 1'b0;
                end

                // A load is only accepted while pend is clear, so it never
                // collides with the swap above. A load taken on a wrap or sync
                // edge therefore waits for the following wrap or sync.
                if (accept && (ld_ch == 4'(i))) begin
                    pend_div[i] <= ld_div;
                    pend[i]     <= 1'b1;
                end
            end
        end
    end

endmodule
